// File: rtl/encrypt_controller.sv
// rtl/encrypt_controller.sv - LWE encryption sequencer: public-key row walk, select gating, mod-q accumulate, per-column output.
module encrypt_controller #(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 10,
    parameter int DIMENSION          = 10,
    parameter int DIM_WIDTH          = 4,
    parameter int BIG_N              = 30,
    parameter int ROW_WIDTH          = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [PLAINTEXT_WIDTH-1:0]  plaintext,
    input  logic [BIG_N-1:0]            select_bits,
    output logic                        busy,
    output logic                        pk_rd_en,
    output logic [ROW_WIDTH-1:0]        pk_row,
    output logic [DIM_WIDTH-1:0]        pk_col,
    input  logic [CIPHERTEXT_WIDTH-1:0] pk_rd_data,
    output logic                        ct_valid,
    input  logic                        ct_ready,
    output logic [CIPHERTEXT_WIDTH-1:0] ct_data,
    output logic [DIM_WIDTH-1:0]        ct_index,
    output logic                        done
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUTPUT} state_t;

    localparam int LP_SHIFT = $clog2(CIPHERTEXT_MODULUS) - $clog2(PLAINTEXT_MODULUS);
    localparam logic [DIM_WIDTH-1:0] LP_LAST_COL = DIM_WIDTH'(DIMENSION);
    localparam logic [ROW_WIDTH-1:0] LP_LAST_ROW = ROW_WIDTH'(BIG_N - 1);

    state_t                        r_state;
    state_t                        w_next;
    logic [DIM_WIDTH-1:0]          r_col;
    logic [ROW_WIDTH-1:0]          r_row;
    logic [CIPHERTEXT_WIDTH-1:0]   r_acc;
    logic [PLAINTEXT_WIDTH-1:0]    r_pt;
    logic [BIG_N-1:0]              r_sel;
    logic                          r_rd_d;
    logic                          r_sel_d;
    logic                          r_done;
    logic                          w_handshake;
    logic                          w_last_col;
    logic [CIPHERTEXT_WIDTH-1:0]   w_scaled;

    assign w_handshake = (r_state == S_OUTPUT) && ct_ready;
    assign w_last_col  = (r_col == LP_LAST_COL);
    assign w_scaled    = CIPHERTEXT_WIDTH'(r_pt) << LP_SHIFT;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_ISSUE;
            S_ISSUE:  if (r_row == LP_LAST_ROW) w_next = S_DRAIN;
            S_DRAIN:  w_next = S_OUTPUT;
            S_OUTPUT: if (ct_ready) w_next = w_last_col ? S_IDLE : S_ISSUE;
            default:  w_next = S_IDLE;
        endcase
    end

    // r_rd_d marks cycles whose pk_rd_data answers a read; only those accumulate.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_acc   <= '0;
            r_pt    <= '0;
            r_sel   <= '0;
            r_rd_d  <= 1'b0;
            r_sel_d <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_rd_d  <= (r_state == S_ISSUE);
            r_sel_d <= r_sel[r_row];
            r_done  <= w_handshake && w_last_col;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pt  <= plaintext;
                        r_sel <= select_bits;
                        r_col <= '0;
                        r_row <= '0;
                        r_acc <= '0;
                    end
                end
                S_ISSUE: begin
                    r_row <= (r_row == LP_LAST_ROW) ? '0 : r_row + 1'b1;
                    if (r_rd_d) r_acc <= r_acc + (r_sel_d ? pk_rd_data : '0);
                end
                S_DRAIN: begin
                    r_acc <= r_acc + (r_sel_d ? pk_rd_data : '0);
                end
                S_OUTPUT: begin
                    if (ct_ready && !w_last_col) begin
                        r_col <= r_col + 1'b1;
                        r_row <= '0;
                        r_acc <= (r_col + 1'b1 == LP_LAST_COL) ? w_scaled : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign pk_rd_en = (r_state == S_ISSUE);
    assign pk_row   = pk_rd_en ? r_row : '0;
    assign pk_col   = pk_rd_en ? r_col : '0;
    assign ct_valid = (r_state == S_OUTPUT);
    assign ct_data  = ct_valid ? r_acc : '0;
    assign ct_index = ct_valid ? r_col : '0;
    assign done     = r_done;
endmodule

// File: tb/tb_encrypt_controller.sv
// tb/tb_encrypt_controller.sv - directed-vector bench for encrypt_controller.
module tb_encrypt_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  plaintext = '0;
    logic [29:0] select_bits = '0;
    logic        busy, pk_rd_en, ct_valid, done;
    logic [4:0]  pk_row;
    logic [3:0]  pk_col, ct_index;
    logic [9:0]  pk_rd_data = '0;
    logic        ct_ready = 1'b1;
    logic [9:0]  ct_data;

    logic [9:0]  pk_mem [0:29][0:10];
    logic [9:0]  words [0:10];
    int          n_vec = 0, n_miss = 0;
    int          cyc = 0, t0 = 0;
    int          got_cnt, done_cyc, first_valid;
    bit          order_err, stall_bad, timeout, aborted;

    encrypt_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .plaintext(plaintext),
        .select_bits(select_bits), .busy(busy), .pk_rd_en(pk_rd_en),
        .pk_row(pk_row), .pk_col(pk_col), .pk_rd_data(pk_rd_data),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
        .ct_index(ct_index), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency key RAM; garbage when no read was issued.
    always @(posedge clk) begin
        if (pk_rd_en && pk_row < 5'd30 && pk_col <= 4'd10) pk_rd_data <= pk_mem[pk_row][pk_col];
        else pk_rd_data <= 10'($urandom);
    end

    task automatic fill_all(input logic [9:0] v);
        for (int r = 0; r < 30; r++) for (int c = 0; c < 11; c++) pk_mem[r][c] = v;
    endtask

    task automatic run_enc(input logic [5:0] pt, input logic [29:0] sel, input int stall_col,
                           input int stall_n, input bit busy_start, input int abort_col);
        int cyc_rel, stall_left;
        logic [9:0] hold;
        got_cnt = 0; done_cyc = -1; first_valid = -1; order_err = 0; stall_bad = 0;
        timeout = 1; aborted = 0; stall_left = stall_n; hold = '0;
        for (int c = 0; c < 11; c++) words[c] = 'x;
        @(negedge clk);
        plaintext = pt; select_bits = sel; start = 1'b1; ct_ready = 1'b1; t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0; plaintext = 6'($urandom); select_bits = 30'($urandom);
        for (int k = 0; k < 2000; k++) begin
            cyc_rel = cyc - t0 + 1;
            if (done) begin
                done_cyc = cyc_rel; timeout = 0; break;
            end
            if (abort_col >= 0 && pk_rd_en && pk_col == 4'(abort_col) && pk_row == 5'd10) begin
                rst_n = 1'b1; aborted = 1; timeout = 0; break;
            end
            start = busy_start && (cyc_rel == 100);
            ct_ready = 1'b1;
            if (ct_valid) begin
                if (first_valid < 0) first_valid = cyc_rel;
                if (pk_rd_en) stall_bad = 1;
                if (stall_n > 0 && ct_index == 4'(stall_col)) begin
                    if (stall_left == stall_n) hold = ct_data;
                    else if (ct_data !== hold) stall_bad = 1;
                end
                if (stall_n > 0 && ct_index == 4'(stall_col) && stall_left > 0) begin
                    ct_ready = 1'b0; stall_left--;
                end else begin
                    if (ct_index != 4'(got_cnt)) order_err = 1;
                    if (ct_index <= 4'd10) words[ct_index] = ct_data;
                    got_cnt++;
                end
            end
            @(negedge clk);
        end
        start = 1'b0; ct_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, pk_rd_en, pk_row, pk_col, ct_valid, ct_data, ct_index, done} !== '0) begin
            n_miss++; $display("FAIL reset_outputs got %h exp 0", {busy, pk_rd_en, pk_row, pk_col, ct_valid, ct_data, ct_index, done});
        end
        rst_n = 1'b0; start = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_start_ignored busy got %b exp 0", busy); end
    endtask

    task automatic test_zero_select();
        fill_all(10'd123);
        run_enc(6'd5, 30'h0, -1, 0, 0, -1);
        n_vec++; if (timeout) begin n_miss++; $display("FAIL t1_timeout got 1 exp 0"); end
        n_vec++; if (first_valid != 32) begin n_miss++; $display("FAIL t1_first_valid got %0d exp 32", first_valid); end
        n_vec++; if (done_cyc != 353) begin n_miss++; $display("FAIL t1_done_cycle got %0d exp 353", done_cyc); end
        n_vec++; if (order_err || got_cnt != 11) begin n_miss++; $display("FAIL t1_order got cnt %0d err %0d exp 11 0", got_cnt, order_err); end
        for (int c = 0; c < 11; c++) begin
            n_vec++;
            if (words[c] !== ((c == 10) ? 10'd80 : 10'd0)) begin
                n_miss++; $display("FAIL t1_word%0d got %0d exp %0d", c, words[c], (c == 10) ? 80 : 0);
            end
        end
    endtask

    task automatic test_all_ones();
        fill_all(10'd1);
        run_enc(6'd5, '1, -1, 0, 0, -1);
        n_vec++; if (done_cyc != 353) begin n_miss++; $display("FAIL t2_done_cycle got %0d exp 353", done_cyc); end
        for (int c = 0; c < 11; c++) begin
            n_vec++;
            if (words[c] !== ((c == 10) ? 10'd110 : 10'd30)) begin
                n_miss++; $display("FAIL t2_word%0d got %0d exp %0d", c, words[c], (c == 10) ? 110 : 30);
            end
        end
    endtask

    task automatic test_wrap();
        fill_all(10'd1023);
        run_enc(6'd0, '1, -1, 0, 0, -1);
        n_vec++; if (timeout) begin n_miss++; $display("FAIL t3_timeout got 1 exp 0"); end
        for (int c = 0; c < 11; c++) begin
            n_vec++;
            if (words[c] !== 10'd994) begin n_miss++; $display("FAIL t3_word%0d got %0d exp 994", c, words[c]); end
        end
    endtask

    task automatic test_row_gate();
        fill_all(10'd500);
        for (int c = 0; c < 11; c++) pk_mem[0][c] = 10'(c + 7);
        run_enc(6'd3, 30'h1, -1, 0, 0, -1);
        for (int c = 0; c < 11; c++) begin
            n_vec++;
            if (words[c] !== ((c == 10) ? 10'd65 : 10'(c + 7))) begin
                n_miss++; $display("FAIL t4_word%0d got %0d exp %0d", c, words[c], (c == 10) ? 65 : c + 7);
            end
        end
    endtask

    task automatic test_stall_and_busy_start();
        fill_all(10'd1);
        run_enc(6'd5, '1, 3, 5, 1, -1);
        n_vec++; if (stall_bad) begin n_miss++; $display("FAIL t5_stall_stable got unstable/read exp stable"); end
        n_vec++; if (done_cyc != 358) begin n_miss++; $display("FAIL t5_done_cycle got %0d exp 358", done_cyc); end
        n_vec++; if (order_err || got_cnt != 11) begin n_miss++; $display("FAIL t5_order got cnt %0d err %0d exp 11 0", got_cnt, order_err); end
        for (int c = 0; c < 11; c++) begin
            n_vec++;
            if (words[c] !== ((c == 10) ? 10'd110 : 10'd30)) begin
                n_miss++; $display("FAIL t5_word%0d got %0d exp %0d", c, words[c], (c == 10) ? 110 : 30);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        fill_all(10'd1);
        run_enc(6'd5, '1, -1, 0, 0, 4);
        #1;
        n_vec++; if (!aborted) begin n_miss++; $display("FAIL t6_reached_col4 got 0 exp 1"); end
        n_vec++;
        if ({busy, pk_rd_en, pk_row, pk_col, ct_valid, ct_data, ct_index, done} !== '0) begin
            n_miss++; $display("FAIL t6_reset_outputs got %h exp 0", {busy, pk_rd_en, pk_row, pk_col, ct_valid, ct_data, ct_index, done});
        end
        @(negedge clk); rst_n = 1'b0;
        run_enc(6'd5, '1, -1, 0, 0, -1);
        n_vec++; if (done_cyc != 353) begin n_miss++; $display("FAIL t6_done_cycle got %0d exp 353", done_cyc); end
        for (int c = 0; c < 11; c++) begin
            n_vec++;
            if (words[c] !== ((c == 10) ? 10'd110 : 10'd30)) begin
                n_miss++; $display("FAIL t6_word%0d got %0d exp %0d", c, words[c], (c == 10) ? 110 : 30);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_select();
        test_all_ones();
        test_wrap();
        test_row_gate();
        test_stall_and_busy_start();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
